// File: rtl/ascon_stream_loader_if.sv
// Word-stream bundle for ascon_stream_loader: frame input channel plus result output channel.
// auth_fail is present only when ASCON_TAG_CHECK_EN is defined.
interface ascon_stream_loader_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_decrypt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
`ifdef ASCON_TAG_CHECK_EN
    logic         auth_fail;
`endif

    modport slave (
        input  in_valid, in_data, in_decrypt, out_ready,
        output in_ready, out_valid, out_data, out_last
`ifdef ASCON_TAG_CHECK_EN
        , output auth_fail
`endif
    );

    modport master (
        output in_valid, in_data, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data, out_last
`ifdef ASCON_TAG_CHECK_EN
        , input auth_fail
`endif
    );
endinterface

// File: rtl/ascon_stream_loader.sv
// Word-serial front end for the Ascon AEAD core: loads key/nonce/AD/data from a W-bit stream,
// sequences ascon_start/ascon_ready, returns data+tag words. Optional: ASCON_TAG_CHECK_EN.
module ascon_stream_loader #(
    parameter int unsigned K = 128,
    parameter int unsigned L = 40,
    parameter int unsigned Y = 104,
    parameter int unsigned W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ascon_stream_loader_if.slave         s,
    output logic [K-1:0]                 core_key,
    output logic [127:0]                 core_nonce,
    output logic [((L > 0) ? L : 1)-1:0] core_ad,
    output logic [((Y > 0) ? Y : 1)-1:0] core_data,
    output logic                         core_decrypt,
    output logic                         core_start,
    input  logic                         core_ready,
    input  logic [((Y > 0) ? Y : 1)-1:0] core_out,
    input  logic [127:0]                 core_tag
);
    localparam int unsigned KW = (K + W - 1) / W;
    localparam int unsigned NW = 128 / W;
    localparam int unsigned AW = (L + W - 1) / W;
    localparam int unsigned DW = (Y + W - 1) / W;
    localparam int unsigned TW = 128 / W;
`ifdef ASCON_TAG_CHECK_EN
    localparam int unsigned ETW = TW;
`else
    localparam int unsigned ETW = 0;
`endif
    localparam int unsigned NB = KW, AB = NB + NW, DB = AB + AW, EB = DB + DW;
    localparam int unsigned IN_MAX = EB + ETW;
    localparam int unsigned OUT_N = DW + TW, OBW = OUT_N * W;
    localparam int unsigned LR = (L > 0) ? L : 1, YR = (Y > 0) ? Y : 1;
    // Bits supplied by the last word of each field; the rest of that word is padding.
    localparam int unsigned KL = K - (KW - 1) * W;
    localparam int unsigned NL = 128 - (NW - 1) * W;
    localparam int unsigned AL = (AW > 0) ? L - (AW - 1) * W : 1;
    localparam int unsigned DL = (DW > 0) ? Y - (DW - 1) * W : 1;
    localparam int unsigned ICW = $clog2(IN_MAX + 1), OCW = $clog2(OUT_N + 1);

    localparam logic [2:0] S_LOAD = 3'd0, S_START = 3'd1, S_WAIT = 3'd2, S_ACK = 3'd3, S_SEND = 3'd4;

    logic [2:0]     state;
    logic [ICW-1:0] in_ctr, in_end;
    logic [OCW-1:0] out_ctr;
    logic [K-1:0]   key_q;
    logic [127:0]   nonce_q;
    logic [LR-1:0]  ad_q;
    logic [YR-1:0]  dat_q;
    logic           dec_q;
    logic [OBW-1:0] rbuf;
    int unsigned    wi;

    assign wi = 32'(in_ctr);

`ifdef ASCON_TAG_CHECK_EN
    logic [127:0] etag_q;
    logic         auth_q, tag_bad, dec_now;
    assign dec_now     = (in_ctr == '0) ? s.in_decrypt : dec_q;
    assign in_end      = dec_now ? ICW'(IN_MAX - 1) : ICW'(EB - 1);
    assign tag_bad     = dec_q && (etag_q != core_tag);
    assign s.auth_fail = auth_q;
`else
    assign in_end = ICW'(EB - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            in_ctr  <= '0;
            out_ctr <= '0;
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            dat_q   <= '0;
            dec_q   <= 1'b0;
            rbuf    <= '0;
`ifdef ASCON_TAG_CHECK_EN
            etag_q  <= '0;
            auth_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: if (s.in_valid) begin
                    if (in_ctr == '0) dec_q <= s.in_decrypt;
                    for (int unsigned i = 0; i + 1 < KW; i++)
                        if (wi == i) key_q[K-1-i*W -: W] <= s.in_data;
                    if (wi == KW - 1) key_q[KL-1:0] <= s.in_data[W-1 -: KL];
                    for (int unsigned i = 0; i + 1 < NW; i++)
                        if (wi == NB + i) nonce_q[127-i*W -: W] <= s.in_data;
                    if (wi == NB + NW - 1) nonce_q[NL-1:0] <= s.in_data[W-1 -: NL];
                    for (int unsigned i = 0; i + 1 < AW; i++)
                        if (wi == AB + i) ad_q[LR-1-i*W -: W] <= s.in_data;
                    if (AW > 0 && wi == AB + AW - 1) ad_q[AL-1:0] <= s.in_data[W-1 -: AL];
                    for (int unsigned i = 0; i + 1 < DW; i++)
                        if (wi == DB + i) dat_q[YR-1-i*W -: W] <= s.in_data;
                    if (DW > 0 && wi == DB + DW - 1) dat_q[DL-1:0] <= s.in_data[W-1 -: DL];
`ifdef ASCON_TAG_CHECK_EN
                    for (int unsigned i = 0; i < TW; i++)
                        if (wi == EB + i) etag_q[127-i*W -: W] <= s.in_data;
`endif
                    if (in_ctr == in_end) begin
                        in_ctr <= '0;
                        state  <= S_START;
                    end else begin
                        in_ctr <= in_ctr + 1'b1;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: if (core_ready) begin
                    // Data area pad bits stay zero; tag lands in the low 128 bits.
                    rbuf <= '0;
`ifdef ASCON_TAG_CHECK_EN
                    auth_q <= tag_bad;
                    if (!tag_bad) rbuf[OBW-1 -: YR] <= core_out;
`else
                    rbuf[OBW-1 -: YR] <= core_out;
`endif
                    rbuf[127:0] <= core_tag;
                    state       <= S_ACK;
                end
                S_ACK: begin
                    out_ctr <= '0;
                    state   <= S_SEND;
                end
                S_SEND: if (s.out_ready) begin
                    if (out_ctr == OCW'(OUT_N - 1)) begin
                        out_ctr <= '0;
                        in_ctr  <= '0;
                        state   <= S_LOAD;
                    end else begin
                        out_ctr <= out_ctr + 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign core_key     = key_q;
    assign core_nonce   = nonce_q;
    assign core_ad      = ad_q;
    assign core_data    = dat_q;
    assign core_decrypt = dec_q;
    assign core_start   = (state == S_START) || (state == S_ACK);
    assign s.in_ready   = (state == S_LOAD);
    assign s.out_valid  = (state == S_SEND);
    assign s.out_data   = (state == S_SEND) ? rbuf[(OUT_N - 1 - 32'(out_ctr)) * W +: W] : '0;
    assign s.out_last   = (state == S_SEND) && (out_ctr == OCW'(OUT_N - 1));
endmodule

// File: tb/tb_ascon_stream_loader.sv
// Scoreboard bench for ascon_stream_loader with a behavioural stand-in for the AEAD core.
// Define ASCON_TAG_CHECK_EN for both RTL and bench to exercise the expected-tag path.
module tb_ascon_stream_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_stream_loader_if #(.W(32)) bus ();
    logic [127:0] core_key, core_nonce, core_tag;
    logic [39:0]  core_ad;
    logic [103:0] core_data, core_out;
    logic         core_decrypt, core_start, core_ready;

    ascon_stream_loader #(.K(128), .L(40), .Y(104), .W(32)) dut (
        .clk(clk), .rst(rst), .s(bus),
        .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad),
        .core_data(core_data), .core_decrypt(core_decrypt), .core_start(core_start),
        .core_ready(core_ready), .core_out(core_out), .core_tag(core_tag)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic abort_run(input string nm);
        errors++;
        checks++;
        $display("FAIL %s: bound expired", nm);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "run aborted");
    endtask

    // Toy cipher standing in for Ascon: XOR keystream plus a linear tag over the plaintext.
    function automatic logic [103:0] ks_f(input logic [127:0] k, input logic [127:0] n);
        logic [127:0] t;
        t = k ^ {n[70:0], n[127:71]} ^ 128'h3c6ef372a54ff53a510e527f9b05688c;
        return t[127:24];
    endfunction

    function automatic logic [127:0] tag_f(input logic [127:0] k, input logic [127:0] n,
                                           input logic [39:0] a, input logic [103:0] p);
        return {k[95:0], k[127:96]} ^ n ^ {a, 88'h0} ^ {24'h0, p} ^ 128'h1;
    endfunction

    // Core model: latency in [core_min, core_max], holds results until the second start pulse.
    int unsigned core_min = 1, core_max = 4, busy;
    logic [1:0]   cst;
    logic [127:0] lk, ln;
    logic [39:0]  la;
    logic [103:0] ld;
    logic         lde;

    always @(posedge clk) begin
        if (rst) begin
            cst <= 2'd0; core_ready <= 1'b0; core_out <= '0; core_tag <= '0; busy <= 0;
        end else begin
            case (cst)
                2'd0: if (core_start) begin
                    lk <= core_key; ln <= core_nonce; la <= core_ad; ld <= core_data; lde <= core_decrypt;
                    busy <= $urandom_range(core_max, core_min);
                    cst <= 2'd1;
                end
                2'd1: if (busy <= 1) begin
                    core_ready <= 1'b1;
                    core_out   <= ld ^ ks_f(lk, ln);
                    core_tag   <= tag_f(lk, ln, la, lde ? (ld ^ ks_f(lk, ln)) : ld);
                    cst        <= 2'd2;
                end else begin
                    busy <= busy - 1;
                end
                default: if (core_start) begin
                    chk("core_key_hold", core_key, lk);
                    chk("core_fields_hold", {core_nonce, core_decrypt}, {ln, lde});
                    chk("core_ad_data_hold", {core_ad, core_data}, {la, ld});
                    core_ready <= 1'b0;
                    core_out   <= 104'({$urandom(), $urandom(), $urandom(), $urandom()});
                    core_tag   <= {$urandom(), $urandom(), $urandom(), $urandom()};
                    cst        <= 2'd0;
                end
            endcase
        end
    end

    typedef struct { int words; logic auth; } frm_t;
    logic [32:0] exp_q[$];
    frm_t        frm_q[$];

    int unsigned rdy_mode = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom());
            endcase
        end
    end

    int          in_hs, starts;
    logic        stall_p, stall_l;
    logic [31:0] stall_d;
    logic [32:0] e;
    frm_t        f;

    always @(negedge clk) begin
        if (rst) begin
            in_hs = 0; starts = 0; stall_p = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) in_hs++;
            if (core_start) starts++;
            if (core_start || bus.out_valid) chk("in_ready_outside_load", bus.in_ready, 0);
            if (stall_p) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, stall_d);
                chk("stall_last", bus.out_last, stall_l);
            end
            stall_p = bus.out_valid && !bus.out_ready;
            stall_d = bus.out_data;
            stall_l = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {1'b1, bus.out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[31:0]);
                    chk("out_last", bus.out_last, e[32]);
                end
                if (bus.out_last) begin
                    if (frm_q.size() == 0) begin
                        chk("unexpected_frame_end", 1, 0);
                    end else begin
                        f = frm_q.pop_front();
                        chk("words_in", in_hs, f.words);
                        chk("start_pulses", starts, 2);
`ifdef ASCON_TAG_CHECK_EN
                        chk("auth_fail", bus.auth_fail, f.auth);
`endif
                    end
                    in_hs = 0;
                    starts = 0;
                end
            end
        end
    end

    int unsigned gap_pct = 0;

    task automatic send_word(input logic [31:0] d, input logic dec);
        int n = 0;
        while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom();
            @(posedge clk); #1;
        end
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_decrypt = dec;
        @(negedge clk);
        while (!bus.in_ready) begin
            n++;
            if (n > 500) abort_run("in_accept_timeout");
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    // Expected result computed from the frame contents; words pushed before stimulus is issued.
    task automatic run_frame(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                             input logic [103:0] d, input logic dec, input logic bad, input logic expect_it);
        logic [103:0] o, pt;
        logic [127:0] t;
        logic [447:0] img;
        logic [255:0] oimg;
        logic         fail;
        int           nw;
        pt   = dec ? (d ^ ks_f(k, n)) : d;
        o    = d ^ ks_f(k, n);
        t    = tag_f(k, n, a, pt);
        fail = 1'b0;
        nw   = 14;
`ifdef ASCON_TAG_CHECK_EN
        if (dec) nw = 18;
        if (dec && bad) fail = 1'b1;
`endif
        if (fail) o = '0;
        img  = {k, n, a, 24'($urandom()), d, 24'($urandom())};
        oimg = {o, 24'h0, t};
        if (expect_it) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, oimg[255-32*i -: 32]});
            frm_q.push_back('{nw, fail});
        end
        for (int i = 0; i < 14; i++) send_word(img[447-32*i -: 32], (i == 0) ? dec : 1'($urandom()));
`ifdef ASCON_TAG_CHECK_EN
        if (dec) begin
            logic [127:0] et;
            et = t ^ {127'h0, bad};
            for (int i = 0; i < 4; i++) send_word(et[127-32*i -: 32], 1'($urandom()));
        end
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 || frm_q.size() != 0) begin
            n++;
            if (n > 3000) abort_run("drain_timeout");
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    logic [127:0] k1, n1;
    logic [39:0]  a1;
    logic [103:0] p1, c1;

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_decrypt = 1'b0;
        k1 = 128'h000102030405060708090A0B0C0D0E0F;
        n1 = 128'h101112131415161718191A1B1C1D1E1F;
        a1 = 40'h0001020304;
        p1 = 104'h000102030405060708090A0B0C;
        c1 = p1 ^ ks_f(k1, n1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_data", {core_data, core_ad, core_decrypt}, 0);

        run_frame(k1, n1, a1, p1, 1'b0, 1'b0, 1'b1);
        run_frame(k1, n1, a1, c1, 1'b1, 1'b0, 1'b1);
        wait_idle();

        gap_pct = 40; rdy_mode = 1;
        run_frame(k1, n1, a1, p1, 1'b0, 1'b0, 1'b1);
        run_frame(k1, n1, a1, c1, 1'b1, 1'b0, 1'b1);
`ifdef ASCON_TAG_CHECK_EN
        run_frame(k1, n1, a1, c1, 1'b1, 1'b1, 1'b1);
        run_frame(k1, n1, a1, c1, 1'b1, 1'b0, 1'b1);
`endif
        wait_idle();

        // Reset while the loader waits on a slow core, then a clean frame.
        core_min = 12; core_max = 12; gap_pct = 0; rdy_mode = 0;
        run_frame(k1, n1, a1, p1, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        begin
            int n = 0;
            while (!core_start) begin
                n++;
                if (n > 100) abort_run("start_timeout");
                @(negedge clk);
            end
        end
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("wait_rst_in_ready", bus.in_ready, 1);
        chk("wait_rst_out_valid", bus.out_valid, 0);
        chk("wait_rst_core_start", core_start, 0);
        core_min = 1; core_max = 4;
        run_frame(k1, n1, a1, p1, 1'b0, 1'b0, 1'b1);

        rdy_mode = 2;
        for (int i = 0; i < 12; i++) begin
            gap_pct = $urandom_range(50);
            run_frame({$urandom(), $urandom(), $urandom(), $urandom()},
                      {$urandom(), $urandom(), $urandom(), $urandom()},
                      40'({$urandom(), $urandom()}),
                      104'({$urandom(), $urandom(), $urandom(), $urandom()}),
                      1'($urandom()), 1'($urandom()), 1'b1);
        end
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        abort_run("watchdog");
    end
endmodule
